// File: rtl/piso_ctrl.sv
// Two-requester parallel-in/serial-out controller: round-robin arbitration,
// MSB-first serialization with stall support and a programmable inter-frame gap.
module piso_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hold,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ready0,
  output logic             ready1,
  output logic             serial_out,
  output logic             ser_valid,
  output logic             frame_first,
  output logic             frame_last,
  output logic             grant_id,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             prio;   // requester favoured on the next contention
  logic             winner;

  always_comb begin
    state_next  = state;
    ready0      = 1'b0;
    ready1      = 1'b0;
    serial_out  = 1'b0;
    ser_valid   = 1'b0;
    frame_first = 1'b0;
    frame_last  = 1'b0;
    winner      = (req0 & req1) ? prio : ~req0;
    case (state)
      S_IDLE: begin
        ready0 = en & req0 & ~winner;
        ready1 = en & req1 & winner;
        if (ready0 | ready1) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        ser_valid   = ~hold;
        serial_out  = ~hold & shift_reg[WIDTH-1];
        frame_first = ~hold & (bit_cnt == '0);
        frame_last  = ~hold & (bit_cnt == CW'(WIDTH-1));
        if (frame_last) state_next = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == 4'(GAP-1)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      grant_id  <= 1'b0;
      prio      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (ready0 | ready1) begin
            shift_reg <= ready1 ? data1 : data0;
            bit_cnt   <= '0;
            grant_id  <= ready1;
            prio      <= ~ready1;
          end
        end
        S_SHIFT: begin
          if (!hold) begin
            shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            bit_cnt   <= bit_cnt + CW'(1);
            gap_cnt   <= '0;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/piso_ctrl.md
PISO_CTRL -- requirements
Module: piso_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: bits per serialized word, legal 2..16.
REQ-002 Parameter GAP, default 1: idle cycles forced after each frame, legal 0..15.
REQ-003 clk  input  1: single clock; all state updates on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 en  input  1: arbitration enable; low blocks new grants only.
REQ-006 hold  input  1: stall; high freezes shifting and bit count.
REQ-007 req0, req1  input  1 each: requester has a word pending.
REQ-008 data0, data1  input  WIDTH each: parallel words, MSB transmitted first.
REQ-009 ready0, ready1  output  1 each: word accepted at the edge where reqN & readyN.
REQ-010 serial_out  output  1: current serial bit.
REQ-011 ser_valid  output  1: serial_out carries a frame bit this cycle.
REQ-012 frame_first, frame_last  output  1 each: first / last bit of frame.
REQ-013 grant_id  output  1: requester owning the current or last frame.
REQ-014 busy  output  1: state not IDLE.

Function
REQ-015 States: IDLE, SHIFT, GAP.
REQ-016 IDLE: readyN = en & reqN & (N is arbitration winner); at most one ready high; all other outputs combinationally from registers.
REQ-017 Arbitration: round-robin; with both req high, winner is the requester not granted last; with one req high, that one wins.
REQ-018 Acceptance edge: shift_reg <= winner data, bit_cnt <= 0, grant_id <= winner, state -> SHIFT.
REQ-019 SHIFT: serial_out = shift_reg[WIDTH-1], ser_valid = !hold.
REQ-020 SHIFT with hold low: each edge shift_reg shifts left, zero fill; bit_cnt increments.
REQ-021 SHIFT with hold high: shift_reg, bit_cnt, state unchanged; ser_valid, frame_first, frame_last low.
REQ-022 frame_first = ser_valid & (bit_cnt == 0); frame_last = ser_valid & (bit_cnt == WIDTH-1).
REQ-023 Frame end: the edge that shifts with bit_cnt == WIDTH-1 moves to GAP (GAP>0) or IDLE (GAP==0).
REQ-024 First bit on serial_out the cycle after acceptance; exactly WIDTH ser_valid cycles per frame.
REQ-025 GAP: gap_cnt counts GAP cycles, then state -> IDLE; hold ignored; ser_valid low.
REQ-026 Minimum spacing between acceptances: WIDTH + GAP + 1 cycles with hold low.
REQ-027 en low during SHIFT/GAP: frame and gap complete normally; no grant in IDLE until en high.
REQ-028 reqN deasserting after acceptance has no effect on the frame in progress.
REQ-029 serial_out = 0 whenever ser_valid is low.

Reset
REQ-030 rst_n low, any cycle including mid-frame: immediately state IDLE, shift_reg 0, bit_cnt 0, gap_cnt 0.
REQ-031 Reset values: serial_out 0, ser_valid 0, frame_first 0, frame_last 0, busy 0, grant_id 0.
REQ-032 After reset the round-robin pointer favours req0 on the first contention.
REQ-033 Aborted frame discarded; no ready pulse is issued for an aborted word.

Verification
REQ-034 WIDTH=4, GAP=1: req0=1, data0=4'b1011 -> ready0 one cycle; next 4 cycles serial_out 1,0,1,1 with ser_valid 1, frame_first on bit 1, frame_last on bit 4; then 1 GAP cycle; busy low.
REQ-035 req0 and req1 held high, data0=4'hA, data1=4'h5 -> grants alternate 0,1,0,1; acceptances 6 cycles apart; serial streams 1010, 0101 repeated.
REQ-036 hold high 2 cycles after bit 2 of 4'b1100 -> ser_valid low 2 cycles, serial stream still 1,1,0,0, frame 2 cycles longer.
REQ-037 rst_n low during bit 3 -> outputs zero asynchronously; after release, req1 with 4'hF -> clean full frame 1111, grant_id 1.
REQ-038 GAP=0, req1 held, data1=4'h9 -> frames 1001 back-to-back with exactly one IDLE cycle between them.
REQ-039 en low while req0 high -> no ready0, busy 0; en high -> ready0 same cycle.
